// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin candidate picker: rotate valids by rr_ptr, priority-encode, rotate back.
module rr_pick #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [ID_W-1:0]    cand,
  output logic               any_valid
);

  localparam int unsigned SUM_W = ID_W + 1;

  logic [NUM_REQ-1:0] w_rot;
  logic [ID_W-1:0]    w_off;
  logic [SUM_W-1:0]   w_sum;

  assign any_valid = |req_valid;

  always_comb begin
    w_rot = NUM_REQ'({req_valid, req_valid} >> rr_ptr);
    w_off = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = ID_W'(i);
    end
    w_sum = SUM_W'(rr_ptr) + SUM_W'(w_off);
    if (!any_valid) begin
      cand = rr_ptr;
    end else if (w_sum >= SUM_W'(NUM_REQ)) begin
      cand = ID_W'(w_sum - SUM_W'(NUM_REQ));
    end else begin
      cand = ID_W'(w_sum);
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locking arbiter sharing one FIFO write port among NUM_REQ streams.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ    = 4,
  parameter  int unsigned DATA_WIDTH = 8,
  parameter  int unsigned MAX_BURST  = 16,
  localparam int unsigned ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int unsigned CNT_W      = $clog2(MAX_BURST + 1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  output logic [ID_W-1:0]               grant_id,
  output logic                          busy,
  output logic                          burst_err
);

  arb_state_e       r_state,    w_state_nxt;
  logic [ID_W-1:0]  r_owner,    w_owner_nxt;
  logic [ID_W-1:0]  r_rr_ptr,   w_rr_nxt;
  logic [CNT_W-1:0] r_beat_cnt, w_beat_nxt;
  logic             r_burst_err, w_err_nxt;

  logic [ID_W-1:0]       w_cand;
  logic                  w_any_valid;
  logic [ID_W-1:0]       w_sel;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic [NUM_REQ-1:0]    w_ready;
  logic                  w_xfer;
  logic                  w_last;
  logic [CNT_W-1:0]      w_beat_inc;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req_valid (req_valid),
    .rr_ptr    (r_rr_ptr),
    .cand      (w_cand),
    .any_valid (w_any_valid)
  );

  // Combinational grant: owner while locked, otherwise the round-robin candidate.
  always_comb begin
    w_sel      = (r_state == ARB_LOCKED) ? r_owner : w_cand;
    w_sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_sel == ID_W'(i)) w_sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
    w_ready = '0;
    if (rst_n && !fifo_full) w_ready[w_sel] = req_valid[w_sel];
  end

  assign w_xfer       = |(req_valid & w_ready);
  assign w_last       = req_last[w_sel];
  assign req_ready    = w_ready;
  assign fifo_wr_en   = w_xfer;
  assign fifo_wr_data = rst_n ? w_sel_data : '0;
  assign grant_id     = rst_n ? w_sel : '0;
  assign busy         = rst_n && (r_state == ARB_LOCKED);
  assign burst_err    = r_burst_err;

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_rr_nxt    = r_rr_ptr;
    w_beat_nxt  = r_beat_cnt;
    w_err_nxt   = r_burst_err;
    w_beat_inc  = r_beat_cnt + CNT_W'(1);
    case (r_state)
      ARB_IDLE: begin
        if (w_xfer) begin
          // A single-beat limit terminates every burst on its first beat.
          if (w_last || (MAX_BURST == 1)) begin
            w_rr_nxt = ID_W'(rr_next(32'(w_cand), NUM_REQ));
            if (!w_last) w_err_nxt = 1'b1;
          end else begin
            w_state_nxt = ARB_LOCKED;
            w_owner_nxt = w_cand;
            w_beat_nxt  = CNT_W'(1);
          end
        end
      end
      ARB_LOCKED: begin
        if (w_xfer) begin
          w_beat_nxt = w_beat_inc;
          if (w_last || (w_beat_inc == CNT_W'(MAX_BURST))) begin
            w_state_nxt = ARB_IDLE;
            w_rr_nxt    = ID_W'(rr_next(32'(r_owner), NUM_REQ));
            w_beat_nxt  = '0;
            if (!w_last) w_err_nxt = 1'b1;
          end
        end
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ARB_IDLE;
      r_owner     <= '0;
      r_rr_ptr    <= '0;
      r_beat_cnt  <= '0;
      r_burst_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_owner     <= w_owner_nxt;
      r_rr_ptr    <= w_rr_nxt;
      r_beat_cnt  <= w_beat_nxt;
      r_burst_err <= w_err_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench: directed vector table on a 4-requester/4-beat-limit arbiter, plus wrap and scoreboard runs on a 3-requester one.
module tb_fifo_wr_arbiter;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT: NUM_REQ=4, MAX_BURST=4
  logic        m_rst_n, m_full, m_wen, m_busy, m_err;
  logic [3:0]  m_valid, m_last, m_ready;
  logic [31:0] m_data;
  logic [7:0]  m_wdata;
  logic [1:0]  m_grant;

  fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(4)) u_dut (
    .clk(clk), .rst_n(m_rst_n), .req_valid(m_valid), .req_last(m_last), .req_data(m_data),
    .req_ready(m_ready), .fifo_full(m_full), .fifo_wr_en(m_wen), .fifo_wr_data(m_wdata),
    .grant_id(m_grant), .busy(m_busy), .burst_err(m_err)
  );

  // Second DUT: NUM_REQ=3, MAX_BURST=16
  logic        t_rst_n, t_full, t_wen, t_busy, t_err;
  logic [2:0]  t_valid, t_last, t_ready;
  logic [23:0] t_data;
  logic [7:0]  t_wdata;
  logic [1:0]  t_grant;

  fifo_wr_arbiter #(.NUM_REQ(3), .DATA_WIDTH(8), .MAX_BURST(16)) u_dut3 (
    .clk(clk), .rst_n(t_rst_n), .req_valid(t_valid), .req_last(t_last), .req_data(t_data),
    .req_ready(t_ready), .fifo_full(t_full), .fifo_wr_en(t_wen), .fifo_wr_data(t_wdata),
    .grant_id(t_grant), .busy(t_busy), .burst_err(t_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] valid;
    logic [3:0] last;
    logic       full;
    logic [3:0] ready;
    logic       wen;
    logic [1:0] grant;
    logic       busy;
    logic       err;
  } vec_t;

  vec_t tv[$];
  vec_t v;

  task automatic add(input logic rst, input logic [3:0] vl, input logic [3:0] ls, input logic f,
                     input logic [3:0] r, input logic w, input logic [1:0] g, input logic b,
                     input logic e);
    vec_t x;
    x.rst = rst; x.valid = vl; x.last = ls; x.full = f;
    x.ready = r; x.wen = w; x.grant = g; x.busy = b; x.err = e;
    tv.push_back(x);
  endtask

  logic [5:0] src_seq [4];
  logic [5:0] snk_seq [4];
  logic [2:0] xfer, prev_xfer;
  logic [1:0] id;
  logic [7:0] ed;
  int total;

  initial begin
    m_rst_n = 1'b0; m_valid = '0; m_last = '0; m_data = '0; m_full = 1'b0;
    t_rst_n = 1'b0; t_valid = '0; t_last = '0; t_data = '0; t_full = 1'b0;

    //   rst valid last full | ready wen grant busy err
    add(0, 4'hF, 4'hF, 0,  4'h0, 0, 0, 0, 0);
    add(1, 4'hF, 4'hF, 0,  4'h1, 1, 0, 0, 0);
    add(1, 4'hF, 4'hF, 0,  4'h2, 1, 1, 0, 0);
    add(1, 4'hF, 4'hF, 0,  4'h4, 1, 2, 0, 0);
    add(1, 4'hF, 4'hF, 0,  4'h8, 1, 3, 0, 0);
    add(1, 4'hF, 4'hF, 0,  4'h1, 1, 0, 0, 0);
    add(1, 4'h6, 4'h0, 0,  4'h2, 1, 1, 0, 0);   // req1 3-beat burst, req2 waiting
    add(1, 4'h6, 4'h0, 0,  4'h2, 1, 1, 1, 0);
    add(1, 4'h6, 4'h2, 0,  4'h2, 1, 1, 1, 0);
    add(1, 4'h4, 4'h4, 0,  4'h4, 1, 2, 0, 0);
    add(1, 4'h8, 4'h0, 0,  4'h8, 1, 3, 0, 0);   // req3 burst, then 4 full cycles
    add(1, 4'h9, 4'h0, 1,  4'h0, 0, 3, 1, 0);
    add(1, 4'h9, 4'h0, 1,  4'h0, 0, 3, 1, 0);
    add(1, 4'h9, 4'h0, 1,  4'h0, 0, 3, 1, 0);
    add(1, 4'h9, 4'h0, 1,  4'h0, 0, 3, 1, 0);
    add(1, 4'h9, 4'h8, 0,  4'h8, 1, 3, 1, 0);
    add(1, 4'h8, 4'h0, 0,  4'h8, 1, 3, 0, 0);   // req3 never last: forced release at beat 4
    add(1, 4'h8, 4'h0, 0,  4'h8, 1, 3, 1, 0);
    add(1, 4'h8, 4'h0, 1,  4'h0, 0, 3, 1, 0);
    add(1, 4'h8, 4'h0, 0,  4'h8, 1, 3, 1, 0);
    add(1, 4'h8, 4'h0, 0,  4'h8, 1, 3, 1, 0);
    add(1, 4'h9, 4'hF, 0,  4'h1, 1, 0, 0, 1);
    add(1, 4'h4, 4'h0, 0,  4'h4, 1, 2, 0, 1);   // req2 locked, then reset pulse
    add(1, 4'h4, 4'h0, 0,  4'h4, 1, 2, 1, 1);
    add(0, 4'h5, 4'h0, 0,  4'h0, 0, 0, 0, 1);
    add(1, 4'h5, 4'h5, 0,  4'h1, 1, 0, 0, 0);
    add(1, 4'h4, 4'h4, 0,  4'h4, 1, 2, 0, 0);
    add(1, 4'h0, 4'h0, 0,  4'h0, 0, 3, 0, 0);
    add(1, 4'h1, 4'h0, 0,  4'h1, 1, 0, 0, 0);   // idle owner keeps the lock
    add(1, 4'h2, 4'h0, 0,  4'h0, 0, 0, 1, 0);
    add(1, 4'h3, 4'h1, 0,  4'h1, 1, 0, 1, 0);
    add(1, 4'h2, 4'h2, 0,  4'h2, 1, 1, 0, 0);

    repeat (2) @(posedge clk);

    for (int k = 0; k < tv.size(); k++) begin
      @(negedge clk);
      v = tv[k];
      m_rst_n = v.rst; m_valid = v.valid; m_last = v.last; m_full = v.full;
      for (int i = 0; i < 4; i++) m_data[i*8 +: 8] = 8'((i + 1) * 16 + k);
      #1;
      ed = v.rst ? 8'((32'(v.grant) + 32'd1) * 32'd16 + 32'(k)) : 8'h00;
      chk($sformatf("v%0d_ready", k), 32'(m_ready), 32'(v.ready));
      chk($sformatf("v%0d_wen",   k), 32'(m_wen),   32'(v.wen));
      chk($sformatf("v%0d_grant", k), 32'(m_grant), 32'(v.grant));
      chk($sformatf("v%0d_busy",  k), 32'(m_busy),  32'(v.busy));
      chk($sformatf("v%0d_err",   k), 32'(m_err),   32'(v.err));
      chk($sformatf("v%0d_wdata", k), 32'(m_wdata), 32'(ed));
    end

    // Three-requester wrap: rr_ptr=1 with 0 and 2 valid picks 2, then 0
    @(negedge clk);
    t_rst_n = 1'b1; t_valid = 3'b001; t_last = 3'b001; t_data = 24'h00_00_A5;
    #1;
    chk("w3_first_grant", 32'(t_grant), 32'd0);
    chk("w3_first_ready", 32'(t_ready), 32'b001);
    chk("w3_first_busy",  32'(t_busy),  32'd0);
    @(negedge clk);
    t_valid = 3'b101; t_last = 3'b101; t_data = 24'hC3_00_A6;
    #1;
    chk("w3_wrap_grant", 32'(t_grant), 32'd2);
    chk("w3_wrap_ready", 32'(t_ready), 32'b100);
    chk("w3_wrap_data",  32'(t_wdata), 32'hC3);
    @(negedge clk);
    #1;
    chk("w3_wrap0_grant", 32'(t_grant), 32'd0);
    chk("w3_wrap0_ready", 32'(t_ready), 32'b001);
    chk("w3_wrap0_err",   32'(t_err),   32'd0);

    // Random traffic with per-requester sequence scoreboard
    for (int i = 0; i < 4; i++) begin src_seq[i] = '0; snk_seq[i] = '0; end
    @(negedge clk);
    t_valid = '0; t_last = '0; t_full = 1'b0;
    prev_xfer = '0;
    total = 0;
    for (int cyc = 0; cyc < 20000 && total < 1000; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (prev_xfer[i]) begin
          src_seq[i] = src_seq[i] + 6'd1;
          total++;
          t_valid[i] = 1'b0;
        end
        if (!t_valid[i]) begin
          t_valid[i] = ($urandom_range(0, 3) != 0);
          t_last[i]  = ($urandom_range(0, 2) == 0);
        end
        t_data[i*8 +: 8] = {2'(i), src_seq[i]};
      end
      t_full = ($urandom_range(0, 4) == 0);
      #1;
      xfer = t_valid & t_ready;
      chk("rnd_wen", 32'(t_wen), 32'(|xfer));
      chk("rnd_full_block", 32'(t_wen & t_full), 32'd0);
      chk("rnd_onehot", 32'($countones(t_ready) <= 1), 32'd1);
      if (t_wen) begin
        id = t_wdata[7:6];
        chk("rnd_gid", 32'(t_grant), 32'(id));
        chk("rnd_seq", 32'(t_wdata[5:0]), 32'(snk_seq[id]));
        snk_seq[id] = snk_seq[id] + 6'd1;
      end
      prev_xfer = xfer;
    end
    for (int i = 0; i < 3; i++) begin
      if (prev_xfer[i]) src_seq[i] = src_seq[i] + 6'd1;
    end
    chk("rnd_budget", 32'(total >= 999), 32'd1);
    for (int i = 0; i < 3; i++) chk($sformatf("rnd_count%0d", i), 32'(snk_seq[i]), 32'(src_seq[i]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin, burst-locking arbiter that shares the single write port of a FIFO among `NUM_REQ` requesters in the FIFO write clock domain. Each requester presents a valid/ready stream with a `last` marker. The arbiter grants one requester at a time and holds the grant until that requester's burst completes. It gates every write against the FIFO `full` flag and drives the FIFO `wr_en`/`wr_data` directly.

## Interface
- `NUM_REQ`, 4: number of requesters; must be ≥2; need not be a power of two.
- `DATA_WIDTH`, 8: FIFO data width.
- `MAX_BURST`, 16: maximum beats per burst before the lock is forcibly released; must be ≥1.
- `clk`  in  1  single clock (the FIFO write clock).
- `rst_n`  in  1  reset; synchronous, active-low.
- `req_valid`  in  NUM_REQ  per-requester data valid.
- `req_last`  in  NUM_REQ  per-requester final beat of the burst; sampled only with valid.
- `req_data`  in  NUM_REQ*DATA_WIDTH  requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_ready`  out  NUM_REQ  one-hot or zero; beat i transfers when `req_valid[i] & req_ready[i]`.
- `fifo_full`  in  1  FIFO full flag.
- `fifo_wr_en`  out  1  FIFO write strobe.
- `fifo_wr_data`  out  DATA_WIDTH  FIFO write data.
- `grant_id`  out  max(1,$clog2(NUM_REQ))  index of the current owner or candidate.
- `busy`  out  1  high while in LOCKED.
- `burst_err`  out  1  sticky flag: a burst exceeded MAX_BURST.

## Operation
- Registered state:
  - FSM state: ARB_IDLE or ARB_LOCKED.
  - `owner`: locked requester index.
  - `rr_ptr`: highest-priority index.
  - `beat_cnt`: width $clog2(MAX_BURST+1).
  - `burst_err`.
- Candidate selection in ARB_IDLE:
  - Search `req_valid` starting at `rr_ptr`, ascending with wrap to 0.
  - The first valid index is the candidate.
  - If no request is valid, the candidate is `rr_ptr`.
- ARB_IDLE grant:
  - `req_ready[cand] = req_valid[cand] & !fifo_full`.
  - A transfer is committed only when a beat actually moves.
  - While `fifo_full` is high, nothing is locked and the candidate is re-evaluated every cycle.
- ARB_IDLE transfer with `req_last=1`:
  - Stay in ARB_IDLE.
  - `rr_ptr ← (cand+1) mod NUM_REQ`.
- ARB_IDLE transfer with `req_last=0`:
  - Go to ARB_LOCKED.
  - `owner ← cand`, `beat_cnt ← 1`.
- ARB_LOCKED grant:
  - Only `owner` can be ready: `req_ready[owner] = req_valid[owner] & !fifo_full`.
  - Other requesters' valids are ignored.
  - An idle owner (valid low) holds the lock indefinitely.
- ARB_LOCKED on each transfer, `beat_cnt` increments. The burst terminates when either:
  - `req_last=1`, or
  - the transfer brings `beat_cnt` to MAX_BURST; in this case also set `burst_err`.
- On burst termination: return to ARB_IDLE, `rr_ptr ← (owner+1) mod NUM_REQ`.
- FIFO drive:
  - `fifo_wr_en = |(req_valid & req_ready)`.
  - `fifo_wr_data` = data of the granted index. It is don't-care when `fifo_wr_en=0`, but is driven from `grant_id` (no X).
- `grant_id` = `owner` in ARB_LOCKED, candidate in ARB_IDLE.
- `burst_err` clears only on reset.
- With MAX_BURST=1, every beat terminates its burst. ARB_LOCKED is never entered; a beat with `req_last=0` sets `burst_err`.

## Timing
- Grant and write path are combinational:
  - A beat presented with `fifo_full=0` is written in the same cycle.
  - Zero-cycle latency from `req_valid` to `fifo_wr_en`.
- FSM, `rr_ptr`, `beat_cnt` and `burst_err` update on the rising `clk` edge following the transfer.
- `fifo_full=1` blocks the transfer in that cycle; `fifo_wr_en` is never asserted while `fifo_full=1`.
- A single requester with continuous valid and `fifo_full=0` achieves one beat per cycle, including back-to-back single-beat bursts.
- Fairness: with all requesters continuously valid, each is granted exactly once per NUM_REQ bursts.
- While `rst_n=0`, all combinational outputs are forced low: `req_ready`, `fifo_wr_en`, `grant_id`, `busy`.
- Reset values at the first edge with `rst_n=0`:
  - state=ARB_IDLE, `rr_ptr`=0, `owner`=0, `beat_cnt`=0, `burst_err`=0.
  - Outputs: `busy`=0, `grant_id`=0, `fifo_wr_en`=0, `req_ready`=0, `fifo_wr_data`=0.
- Reset mid-burst abandons the burst. No further beats of that burst are accepted as locked; arbitration restarts from index 0.

## Structure
- Package `fifo_arb_pkg`:
  - state enum `arb_state_e` {ARB_IDLE, ARB_LOCKED}.
  - function `rr_next(idx, n)` for modulo increment.
- Sub-module `rr_pick`:
  - Purely combinational.
  - Inputs: `req_valid[NUM_REQ]`, `rr_ptr`.
  - Outputs: `cand` index, `any_valid`.
  - Implementation: double-width rotate-and-priority-encode.
- Top level holds the FSM, counters, muxing and output gating.

## Test plan
- Reset, then requesters 0..3 all valid, single-beat (`last=1`), `fifo_full=0` → grant order 0,1,2,3,0 on consecutive cycles; `fifo_wr_en` high every cycle; data matches source.
- Requester 1 sends a 3-beat burst while 2 is valid → `busy` high after beat 1; `req_ready[2]`=0 until beat 3; requester 2 is granted on the next cycle; `rr_ptr`=2 then 3.
- `fifo_full=1` asserted for 4 cycles mid-burst → no `fifo_wr_en`, lock and `beat_cnt` unchanged; the burst resumes with the same owner when `full` drops.
- MAX_BURST=4 and requester 3 never asserts `last` → lock released after beat 4; `burst_err`=1 and stays 1; next grant goes to index 0.
- `rst_n` pulsed low for 1 cycle during a locked burst of requester 2 → during reset all outputs 0; afterwards ARB_IDLE, with requester 0 granted first if valid.
- NUM_REQ=3, requesters 0 and 2 valid with `rr_ptr`=1 → candidate 2, then 0 (wrap check); no beat is lost or duplicated over 1000 random beats (scoreboard per requester).
